// File: rtl/nlprg_pkg.sv
// Shared types and constants for the PRNG round-robin server.
package nlprg_pkg;

  // Default PRNG word width; the nlprg10 generator only exists in 10-bit form.
  localparam int N_DEF = 10;

  // Full period of nlprg10, which includes the all-zero word.
  localparam int PERIOD = 1024;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    FAULT  = 2'd2
  } state_e;

endpackage

// File: rtl/nlprg10.sv
// 10-bit nonlinear PRNG: maximal LFSR (x^10 + x^7 + 1) with the de Bruijn
// correction term, so the sequence visits all 1024 words including zero.
// Reset state is zero, which makes o==0 line up with a zero-based counter.
module nlprg10 (
  input  logic       ck,
  input  logic       rst,
  output logic [9:0] o
);

  logic [9:0] s_q, s_d;
  logic       fb;

  // Feedback: LFSR taps, inverted when the low nine bits are all zero so the
  // chain passes through 0x000 between 0x200 and 0x001.
  always_comb begin
    fb  = s_q[9] ^ s_q[6] ^ (s_q[8:0] == 9'd0);
    s_d = {s_q[8:0], fb};
  end

  // State register, cleared asynchronously.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) s_q <= '0;
    else     s_q <= s_d;
  end

  assign o = s_q;

endmodule

// File: rtl/nlprg_rr_server.sv
// Round-robin server handing out one nlprg10 word per grant. A free-running
// cycle counter is cross-checked against the PRNG zero word to detect a
// broken generator period; a mismatch parks the server in FAULT until reset.
module nlprg_rr_server
  import nlprg_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = 4,
  parameter int WARM = 2
) (
  input  logic            ck,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [N-1:0]    data,
  output logic            period_ok,
  output logic            fault,
  output logic            busy
);

  localparam int PW = $clog2(NREQ);
  // Counter value seen in the last WARMUP cycle; WARM of at least 1 assumed.
  localparam logic [N-1:0] WARM_LAST = N'((WARM > 0) ? WARM - 1 : 0);

  state_e          state_q, state_d;
  logic [N-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [N-1:0]    data_q, data_d;

  logic [N-1:0]    prng_o;
  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  int              idx;
  logic            cnt_zero, prng_zero;

  nlprg10 u_prng (
    .ck (ck),
    .rst(rst),
    .o  (prng_o)
  );

  // Cyclic priority search: first requesting index at or after ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_found && req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  assign cnt_zero  = (cnt_q == '0);
  assign prng_zero = (prng_o == '0);

  // Next-state: counter wrap, FSM, grant/data capture and pointer update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    data_d  = data_q;
    cnt_d   = (cnt_q == N'(PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    case (state_q)
      WARMUP: begin
        if (cnt_q == WARM_LAST) state_d = RUN;
      end
      RUN: begin
        // A grant in the cycle that detects a period error is still issued.
        if (pick_found) begin
          gnt_d[pick_idx] = 1'b1;
          data_d          = prng_o;
          ptr_d           = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
        if (cnt_zero != prng_zero) state_d = FAULT;
      end
      default: begin
        // FAULT (and any illegal encoding) is left only through reset.
        state_d = FAULT;
      end
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q <= WARMUP;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

  assign gnt       = gnt_q;
  assign data      = data_q;
  // Decoded from registered state only: high in the cycle cnt has wrapped to 0.
  assign period_ok = (state_q == RUN) && cnt_zero && prng_zero;
  assign fault     = (state_q == FAULT);
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_nlprg_rr_server.sv
// Bench for nlprg_rr_server: a cycle model predicts grant/data per edge,
// pushes the prediction into a scoreboard queue, and the entry is popped and
// compared once the DUT has registered its output.
module tb_nlprg_rr_server;

  localparam int NREQ  = 4;
  localparam int WARM  = 2;
  localparam int M_WARM = 0;
  localparam int M_RUN  = 1;
  localparam int M_FLT  = 2;

  logic            ck  = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic [9:0]      data;
  logic            period_ok, fault, busy;

  always #5 ck = ~ck;

  nlprg_rr_server #(.N(10), .NREQ(NREQ), .WARM(WARM)) dut (
    .ck       (ck),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .data     (data),
    .period_ok(period_ok),
    .fault    (fault),
    .busy     (busy)
  );

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [9:0]      data;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int ok_pulses = 0;

  // Model state
  int         m_state;
  int         m_cnt;
  int         m_ptr;
  logic [9:0] m_prng;
  logic [9:0] m_data;
  bit         force_zero = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference generator: zero is spliced between 0x200 and 0x001 of the LFSR chain.
  function automatic logic [9:0] ref_next(input logic [9:0] s);
    if (s == 10'h200) return 10'h000;
    if (s == 10'h000) return 10'h001;
    return {s[8:0], s[9] ^ s[6]};
  endfunction

  task automatic model_reset();
    m_state = M_WARM;
    m_cnt   = 0;
    m_ptr   = 0;
    m_prng  = 10'h000;
    m_data  = 10'h000;
    sb_q.delete();
  endtask

  // Assert rst asynchronously, check cleared outputs, release after one edge.
  task automatic apply_reset(input string tag);
    #2 rst = 1'b1;
    req = '0;
    #1;
    chk({tag, "_gnt"},       gnt,       0);
    chk({tag, "_data"},      data,      0);
    chk({tag, "_period_ok"}, period_ok, 0);
    chk({tag, "_fault"},     fault,     0);
    chk({tag, "_busy"},      busy,      0);
    @(posedge ck);
    #1 rst = 1'b0;
    model_reset();
    $display("t=%0t reset %s released", $time, tag);
  endtask

  // One clock cycle: drive req, predict, push; after the edge pop and compare.
  task automatic tick(input logic [NREQ-1:0] r);
    exp_t       e;
    logic [9:0] o_eff;
    logic [NREQ-1:0] g;
    int         nstate;
    int         pick;
    @(negedge ck);
    o_eff = force_zero ? 10'h000 : m_prng;
    chk("period_ok", period_ok, (m_state == M_RUN) && (m_cnt == 0) && (o_eff == 10'h000));
    if (period_ok === 1'b1) ok_pulses++;
    req  = r;
    g    = '0;
    pick = -1;
    if (m_state == M_RUN) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (pick < 0 && r[i]) pick = i;
      end
      if (pick >= 0) begin
        g[pick] = 1'b1;
        m_ptr   = (pick + 1) % NREQ;
        m_data  = o_eff;
      end
    end
    nstate = m_state;
    if (m_state == M_WARM && m_cnt == WARM - 1) nstate = M_RUN;
    if (m_state == M_RUN && ((o_eff == 10'h000) != (m_cnt == 0))) nstate = M_FLT;
    e.gnt  = g;
    e.data = m_data;
    sb_q.push_back(e);
    m_state = nstate;
    m_cnt   = (m_cnt + 1) % 1024;
    m_prng  = ref_next(m_prng);
    @(posedge ck);
    #1;
    e = sb_q.pop_front();
    chk("gnt",   gnt,   e.gnt);
    chk("data",  data,  e.data);
    chk("busy",  busy,  m_state == M_RUN);
    chk("fault", fault, m_state == M_FLT);
    $display("t=%0t req=%b gnt=%b data=%h busy=%b fault=%b", $time, r, gnt, data, busy, fault);
  endtask

  int  seq33[10] = '{0, 0, 1, 2, 4, 8, 1, 2, 4, 8};
  int  req37[6]  = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1010};
  int  exp37[6]  = '{0, 0, 2, 8, 8, 2};
  bit  seen[1024];
  int  n_grants;

  initial begin
    model_reset();

    // Round robin over all requesters from reset release
    apply_reset("rst0");
    for (int k = 0; k < 10; k++) begin
      tick(4'b1111);
      chk("seq_all", gnt, seq33[k]);
    end

    // Reset mid-stream while 0010 is the next grant; sequence restarts cleanly
    apply_reset("rst1");
    for (int k = 0; k < 3; k++) tick(4'b1111);
    chk("pre_rst_gnt", gnt, 1);
    apply_reset("rst_mid");
    for (int k = 0; k < 10; k++) begin
      tick(4'b1111);
      chk("seq_after_rst", gnt, seq33[k]);
    end

    // Withdrawn request: bit 1 dropped on its turn, bit 3 served, ptr back to 0
    apply_reset("rst2");
    for (int k = 0; k < 6; k++) begin
      tick(req37[k][NREQ-1:0]);
      chk("withdraw", gnt, exp37[k]);
    end

    // Forced zero PRNG word at cnt=37 -> FAULT, sticky until reset
    apply_reset("rst3");
    while (m_cnt != 37) tick(4'b1111);
    force dut.prng_o = 10'h000;
    force_zero = 1'b1;
    tick(4'b1111);
    release dut.prng_o;
    force_zero = 1'b0;
    chk("fault_set", fault, 1);
    for (int k = 0; k < 5; k++) begin
      tick(4'b1111);
      chk("fault_no_gnt", gnt, 0);
    end
    apply_reset("rst_fault");

    // Single requester across a full period: unique words, one period_ok pulse
    apply_reset("rst4");
    for (int k = 0; k < 1024; k++) seen[k] = 1'b0;
    n_grants  = 0;
    ok_pulses = 0;
    for (int t = 0; t < 1026; t++) begin
      tick(4'b0100);
      if (gnt != 0 && n_grants < 1023) begin
        chk("uniq", seen[data], 0);
        seen[data] = 1'b1;
        n_grants++;
      end
    end
    chk("grant_count", n_grants, 1023);
    chk("period_pulses", ok_pulses, 1);
    chk("no_fault_full_period", fault, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time bound on the whole run
  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time bound, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
